capture_ctrl: RTL
=================

# capture_ctrl

Capture sequencer for the logic-analyzer datapath. It sits between the 8-to-32 packer output (a strobe-qualified stream of 32-bit words in the recovered LVDS clock domain) and the capture FIFO write port. Software arms it; it watches the word stream for a masked trigger pattern, then forwards exactly the programmed number of words to the FIFO and reports completion, overflow and progress. The input stream has no backpressure, so any word the FIFO cannot accept is dropped and flagged, never stalled.

## Interface
- `DATA_LEN`, 32: width of packed words.
- `CNT_LEN`, 16: width of the capture length and word counter.

- `clk`  in  1  capture clock (recovered LVDS clock, same as the packer).
- `rst`  in  1  asynchronous, active-high reset.
- `arm`  in  1  single-cycle pulse: start a capture.
- `abort`  in  1  single-cycle pulse: cancel and return to IDLE.
- `trig_mask`  in  DATA_LEN  bit = 1 means the bit participates in the trigger compare.
- `trig_value`  in  DATA_LEN  trigger pattern.
- `capture_len`  in  CNT_LEN  number of words to capture, trigger word included.
- `in_valid`  in  1  packer word valid.
- `in_data`  in  DATA_LEN  packer word.
- `out_ready`  in  1  FIFO can accept a word (not full).
- `out_valid`  out  1  FIFO write enable.
- `out_data`  out  DATA_LEN  FIFO write data.
- `busy`  out  1  state is ARMED or CAPTURE.
- `triggered`  out  1  sticky: trigger seen in this run.
- `done`  out  1  state is DONE.
- `overflow`  out  1  sticky: at least one word dropped in this run.
- `word_cnt`  out  CNT_LEN  words consumed in CAPTURE this run.

## Operation
- States: IDLE, ARMED, CAPTURE, DONE.
- **Latching.** `trig_mask`, `trig_value` and `capture_len` are latched on `arm`. They are ignored at all other times.
- **IDLE/DONE + `arm`.** Go to ARMED. Clear `triggered`, `overflow` and `word_cnt`.
- **`arm` in ARMED/CAPTURE.** Ignored.
- **ARMED.**
  - Match condition: `in_valid` and `(in_data & mask) == (value & mask)`.
  - With mask = 0, the first valid word matches.
  - On a match, set `triggered` and handle the trigger word as the first CAPTURE word.
  - If the latched length is 0, go directly to DONE and write nothing.
- **CAPTURE.** Each `in_valid` word increments `word_cnt`.
  - If `out_ready` = 1, forward the word.
  - If `out_ready` = 0, drop the word and set `overflow`. Dropped words still count, so a capture always spans a fixed window of the stream.
  - When `word_cnt` reaches the latched length, go to DONE.
- **DONE.** Holds, with flags stable, until `arm` or `abort`.
- **`abort`.** From any state, go to IDLE. Flags and `word_cnt` are retained for readout. `abort` wins over a simultaneous `arm`.
- **Paused stream.** Cycles with `in_valid` = 0 (stream pauses) do not advance anything.
- **`word_cnt`.** Never exceeds the latched length. No wrap-around.

## Timing
- **Reset values.** All outputs are 0; state is IDLE.
- **`arm` at edge N.** `busy` = 1 from cycle N+1. A word at edge N is not compared; a word at edge N+1 is.
- **Output latency.** One cycle from input to `out_valid`/`out_data` (registered). `out_valid` is high for one cycle per forwarded word.
- **Trigger.** A word matching at edge T appears on `out_data` with `out_valid` at T+1. `triggered` = 1 and `word_cnt` = 1 from T+1.
- **Last word.** The last word accepted at edge L gives `out_valid` = 1, `done` = 1 and `busy` = 0 all at L+1.
- **Abort at edge A.** `busy` = 0 from A+1. A word presented at A is not forwarded.
- **`out_ready`.** Sampled in the same cycle as `in_valid`. There is no internal buffering.
- **Reset mid-capture.** Immediate return to reset values. `out_valid` deasserts asynchronously.

## Structure
- Package `capture_pkg`:
  - state enum `cap_state_t` (IDLE, ARMED, CAPTURE, DONE);
  - default `DATA_LEN`/`CNT_LEN` constants.
- Sub-module `trig_match`: combinational masked comparator (`data`, `mask`, `value` → `hit`). It is reused by a later multi-stage trigger.
- The FSM, counter, flags and output register live in `capture_ctrl`.

## Test plan
- **Immediate trigger.** `mask` = 0, `capture_len` = 4, `arm`, then words 0x11..0x66 contiguous. Required: `out_data` 0x11, 0x22, 0x33, 0x44. `done` = 1 with the 0x44 write. 0x55 is not written.
- **Pattern trigger across pauses.** `mask` = 0x000000FF, `value` = 0x000000A5. Stream 0x100, 0x2A5, pause of 16 cycles, 0x300, 0x400, with `len` = 3. Required: writes 0x2A5, 0x300, 0x400. `word_cnt` = 3.
- **Overflow.** `len` = 4 and `out_ready` low during the third word. Required: 3 writes, `overflow` = 1, `word_cnt` = 4, `done` = 1.
- **Abort/arm collision.** Abort during CAPTURE after 2 words, with `arm` in the same cycle. Required: IDLE, `busy` = 0, `word_cnt` = 2 retained, no further writes.
- **Zero length.** `len` = 0 and a matching word arrives. Required: DONE next cycle, `triggered` = 1, zero writes.
- **Async reset.** Assert `rst` mid-CAPTURE, between edges. Required: all outputs 0 immediately. After release, `arm` works normally.

Source files
------------

// File: rtl/capture_pkg.sv
// Shared types and default widths for the capture sequencer.
package capture_pkg;

    localparam int DEF_DATA_LEN = 32;
    localparam int DEF_CNT_LEN  = 16;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } cap_state_t;

endpackage : capture_pkg

// File: rtl/trig_match.sv
// Combinational masked comparator: hit when every masked bit of data equals value.
module trig_match #(
    parameter int W = 32
) (
    input  logic [W-1:0] data,
    input  logic [W-1:0] mask,
    input  logic [W-1:0] value,
    output logic         hit
);

    // A zero mask yields an unconditional hit.
    assign hit = (((data ^ value) & mask) == '0);

endmodule : trig_match

// File: rtl/capture_ctrl.sv
// Capture sequencer: waits for a masked trigger word, then forwards a fixed
// window of the packed word stream to the capture FIFO. No backpressure on the
// stream, so words the FIFO cannot take are dropped and flagged.
module capture_ctrl
    import capture_pkg::*;
#(
    parameter int DATA_LEN = DEF_DATA_LEN,
    parameter int CNT_LEN  = DEF_CNT_LEN
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                arm,
    input  logic                abort,
    input  logic [DATA_LEN-1:0] trig_mask,
    input  logic [DATA_LEN-1:0] trig_value,
    input  logic [CNT_LEN-1:0]  capture_len,
    input  logic                in_valid,
    input  logic [DATA_LEN-1:0] in_data,
    input  logic                out_ready,
    output logic                out_valid,
    output logic [DATA_LEN-1:0] out_data,
    output logic                busy,
    output logic                triggered,
    output logic                done,
    output logic                overflow,
    output logic [CNT_LEN-1:0]  word_cnt
);

    cap_state_t          state_q, state_d;
    logic [DATA_LEN-1:0] mask_q, mask_d;
    logic [DATA_LEN-1:0] value_q, value_d;
    logic [CNT_LEN-1:0]  len_q, len_d;
    logic [CNT_LEN-1:0]  cnt_q, cnt_d;
    logic                trig_q, trig_d;
    logic                ovf_q, ovf_d;
    logic                out_valid_q, out_valid_d;
    logic [DATA_LEN-1:0] out_data_q, out_data_d;

    logic                hit;
    logic                take_word;
    logic [CNT_LEN-1:0]  cnt_inc;

    // Trigger compare always uses the copy latched at arm time.
    trig_match #(
        .W (DATA_LEN)
    ) u_trig_match (
        .data  (in_data),
        .mask  (mask_q),
        .value (value_q),
        .hit   (hit)
    );

    assign cnt_inc = cnt_q + CNT_LEN'(1);

    // Next-state, counter, flag and output-register logic.
    always_comb begin
        state_d     = state_q;
        mask_d      = mask_q;
        value_d     = value_q;
        len_d       = len_q;
        cnt_d       = cnt_q;
        trig_d      = trig_q;
        ovf_d       = ovf_q;
        out_valid_d = 1'b0;
        out_data_d  = out_data_q;
        take_word   = 1'b0;

        if (abort) begin
            // Abort beats arm and drops the word of this cycle; flags stay readable.
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (arm) begin
                        state_d = ST_ARMED;
                        mask_d  = trig_mask;
                        value_d = trig_value;
                        len_d   = capture_len;
                        cnt_d   = '0;
                        trig_d  = 1'b0;
                        ovf_d   = 1'b0;
                    end
                end
                ST_ARMED: begin
                    if (in_valid && hit) begin
                        trig_d = 1'b1;
                        if (len_q == '0) begin
                            state_d = ST_DONE;
                        end else begin
                            // The trigger word itself is the first window word.
                            take_word = 1'b1;
                        end
                    end
                end
                ST_CAPTURE: begin
                    take_word = in_valid;
                end
                default: state_d = ST_IDLE;
            endcase

            if (take_word) begin
                // Dropped words still consume a slot of the window.
                cnt_d = cnt_inc;
                if (out_ready) begin
                    out_valid_d = 1'b1;
                    out_data_d  = in_data;
                end else begin
                    ovf_d = 1'b1;
                end
                state_d = (cnt_inc == len_q) ? ST_DONE : ST_CAPTURE;
            end
        end
    end

    // State and datapath registers, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            mask_q      <= '0;
            value_q     <= '0;
            len_q       <= '0;
            cnt_q       <= '0;
            trig_q      <= 1'b0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            mask_q      <= mask_d;
            value_q     <= value_d;
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            trig_q      <= trig_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign busy      = (state_q == ST_ARMED) || (state_q == ST_CAPTURE);
    assign done      = (state_q == ST_DONE);
    assign triggered = trig_q;
    assign overflow  = ovf_q;
    assign word_cnt  = cnt_q;

endmodule : capture_ctrl
